// File: rtl/freq_div_bank_pkg.sv
// Shared constants and helpers for the frequency divider bank.
package freq_div_bank_pkg;

  // Half-period loaded into every channel at reset.
  localparam int DEF_DIV_DFLT  = 50;
  // Display-refresh half-period in clk cycles.
  localparam int DISP_DIV_DFLT = 12500;
  // Largest supported number of divider channels.
  localparam int MAX_CHANNELS  = 8;
  // Default channel count and half-period register width.
  localparam int CHANNELS_DFLT = 4;
  localparam int DIV_W_DFLT    = 16;

  // Index width needed to address n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/freq_div_bank_if.sv
// Control and output bundle of the frequency divider bank.
interface freq_div_bank_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16
);
  import freq_div_bank_pkg::*;

  localparam int SEL_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0] ch_en;
  logic                div_wr;
  logic [SEL_W-1:0]    ch_sel;
  logic [DIV_W-1:0]    div_data;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] tick;
  logic                disp_clk;
  logic                disp_tick;

  // Controller side: drives enables and half-period writes, observes the outputs.
  modport master (
    output ch_en, div_wr, ch_sel, div_data,
    input  clk_out, tick, disp_clk, disp_tick
  );

  // Divider bank side.
  modport slave (
    input  ch_en, div_wr, ch_sel, div_data,
    output clk_out, tick, disp_clk, disp_tick
  );

endinterface

// File: rtl/freq_div_bank_div_channel.sv
// One divider channel: active/shadow half-period, counter, square wave and rise tick.
module div_channel #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] data,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] shd_div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] shd_next;
  logic [DIV_W-1:0] act_next;
  logic [DIV_W-1:0] cnt_next;
  logic             running;
  logic             terminal;
  logic             clk_next;
  logic             tick_next;

  // Next-state decode: A only reloads at a terminal count or while idle; a
  // write landing on the terminal cycle goes straight into A.
  always_comb begin
    shd_next  = wr ? data : shd_div;
    running   = en && (act_div != ZERO);
    terminal  = running && (cnt == (act_div - ONE));
    act_next  = act_div;
    cnt_next  = cnt;
    clk_next  = clk_out;
    tick_next = 1'b0;
    if (!running) begin
      act_next = shd_next;
      cnt_next = ZERO;
      clk_next = 1'b0;
    end else if (terminal) begin
      act_next = shd_next;
      cnt_next = ZERO;
      if (shd_next == ZERO) begin
        // Next half-period stops the channel, so never start a new high phase.
        clk_next = 1'b0;
      end else begin
        clk_next  = ~clk_out;
        tick_next = ~clk_out;
      end
    end else begin
      cnt_next = cnt + ONE;
    end
  end

  // Channel state registers; reset discards any period in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_div <= RST_DIV;
      shd_div <= RST_DIV;
      cnt     <= ZERO;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      act_div <= act_next;
      shd_div <= shd_next;
      cnt     <= cnt_next;
      clk_out <= clk_next;
      tick    <= tick_next;
    end
  end

endmodule

// File: rtl/freq_div_bank.sv
// Bank of independent programmable square-wave dividers plus a display-refresh divider.
module freq_div_bank
  import freq_div_bank_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DFLT,
  parameter int DIV_W    = DIV_W_DFLT,
  parameter int DEF_DIV  = DEF_DIV_DFLT,
  parameter int DISP_DIV = DISP_DIV_DFLT
) (
  input logic           clk,
  input logic           reset,
  freq_div_bank_if.slave bus
);

  localparam int SEL_W  = sel_width(CHANNELS);
  localparam int DISP_W = sel_width(DISP_DIV);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_DIV - 1);
  localparam logic [DISP_W-1:0] DISP_ZERO = {DISP_W{1'b0}};
  localparam logic [DISP_W-1:0] DISP_ONE  = DISP_W'(1);

  logic [CHANNELS-1:0] ch_clk;
  logic [CHANNELS-1:0] ch_tick;
  logic [DISP_W-1:0]   disp_cnt;
  logic                disp_clk;
  logic                disp_tick;

  // One divider per channel; a write is routed only to an in-range channel
  // index, so out-of-range selects match nothing and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = bus.div_wr && (bus.ch_sel == SEL_W'(i));

    div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (bus.ch_en[i]),
      .wr      (wr_hit),
      .data    (bus.div_data),
      .clk_out (ch_clk[i]),
      .tick    (ch_tick[i])
    );
  end

  // Free-running display refresh divider, independent of channel activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_cnt  <= DISP_ZERO;
      disp_clk  <= 1'b0;
      disp_tick <= 1'b0;
    end else if (disp_cnt == DISP_LAST) begin
      disp_cnt  <= DISP_ZERO;
      disp_clk  <= ~disp_clk;
      disp_tick <= ~disp_clk;
    end else begin
      disp_cnt  <= disp_cnt + DISP_ONE;
      disp_tick <= 1'b0;
    end
  end

  assign bus.clk_out   = ch_clk;
  assign bus.tick      = ch_tick;
  assign bus.disp_clk  = disp_clk;
  assign bus.disp_tick = disp_tick;

endmodule
